// File: rtl/sync_fifo.sv
// Synchronous valid/ready FIFO with registered outputs, fill level and almost-full flag.
// Full/empty come from an explicit count, so the pointers wrap freely with no bubble.
module sync_fifo #(
    parameter int G_DATA_SIZE = 8,
    parameter int G_ADDR_SIZE = 2,
    parameter int G_AFULL     = 3
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   s_valid_i,
    output logic                   s_ready_o,
    input  logic [G_DATA_SIZE-1:0] s_data_i,
    output logic                   m_valid_o,
    input  logic                   m_ready_i,
    output logic [G_DATA_SIZE-1:0] m_data_o,
    output logic [G_ADDR_SIZE:0]   fill_o,
    output logic                   afull_o
);

    localparam int                 AW    = G_ADDR_SIZE;
    localparam int                 DEPTH = 2 ** AW;
    localparam logic [AW:0]        DEPTH_C = (AW + 1)'(DEPTH);
    localparam logic [AW:0]        AFULL_C = (AW + 1)'(G_AFULL);
    localparam logic [AW:0]        ONE     = (AW + 1)'(1);

    logic [G_DATA_SIZE-1:0] mem [DEPTH];
    logic [AW:0]            wr;
    logic [AW:0]            rd;
    logic [AW:0]            cnt;

    logic                   push;
    logic                   pop;
    logic                   fwd;
    logic [AW:0]            wr_next;
    logic [AW:0]            rd_next;
    logic [AW:0]            cnt_next;

    always_comb begin
        push     = s_valid_i && s_ready_o;
        pop      = m_valid_o && m_ready_i;
        wr_next  = push ? wr + ONE : wr;
        rd_next  = pop  ? rd + ONE : rd;
        cnt_next = cnt;
        case ({push, pop})
            2'b10:   cnt_next = cnt + ONE;
            2'b01:   cnt_next = cnt - ONE;
            default: cnt_next = cnt;
        endcase
        // The slot at rd_next is being written this edge only when the FIFO
        // would otherwise be empty, so the incoming word must be forwarded.
        fwd = push && (wr[AW-1:0] == rd_next[AW-1:0]);
    end

    // Data path: storage and output register carry no reset.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem[wr[AW-1:0]] <= s_data_i;
        end
        m_data_o <= fwd ? s_data_i : mem[rd_next[AW-1:0]];
    end

    // Control path: pointers, count and registered flags.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr        <= '0;
            rd        <= '0;
            cnt       <= '0;
            s_ready_o <= 1'b0;
            m_valid_o <= 1'b0;
            fill_o    <= '0;
            afull_o   <= 1'b0;
        end else begin
            wr        <= wr_next;
            rd        <= rd_next;
            cnt       <= cnt_next;
            s_ready_o <= (cnt_next < DEPTH_C);
            m_valid_o <= (cnt_next != '0);
            fill_o    <= cnt_next;
            afull_o   <= (cnt_next >= AFULL_C);
        end
    end

endmodule

// File: tb/tb_sync_fifo.sv
// Directed bench for sync_fifo (D=4, afull=3): vector table plus hand-written
// sequences for sustained push/pop and reset in mid-stream.
module tb_sync_fifo;

    logic       clk = 1'b0;
    logic       rst_i;
    logic       s_valid_i;
    logic       s_ready_o;
    logic [7:0] s_data_i;
    logic       m_valid_o;
    logic       m_ready_i;
    logic [7:0] m_data_o;
    logic [2:0] fill_o;
    logic       afull_o;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    sync_fifo #(
        .G_DATA_SIZE(8),
        .G_ADDR_SIZE(2),
        .G_AFULL    (3)
    ) dut (
        .clk_i    (clk),
        .rst_i    (rst_i),
        .s_valid_i(s_valid_i),
        .s_ready_o(s_ready_o),
        .s_data_i (s_data_i),
        .m_valid_o(m_valid_o),
        .m_ready_i(m_ready_i),
        .m_data_o (m_data_o),
        .fill_o   (fill_o),
        .afull_o  (afull_o)
    );

    typedef struct {
        logic       rst;
        logic       sv;
        logic [7:0] sd;
        logic       mr;
        logic       mv;
        logic       sr;
        logic [2:0] fill;
        logic       af;
        logic       cd;
        logic [7:0] md;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic rst, input logic sv, input logic [7:0] sd,
                                input logic mr, input logic mv, input logic sr,
                                input logic [2:0] fill, input logic af, input logic cd,
                                input logic [7:0] md);
        vec_t v;
        v.rst = rst; v.sv = sv; v.sd = sd; v.mr = mr;
        v.mv = mv; v.sr = sr; v.fill = fill; v.af = af; v.cd = cd; v.md = md;
        vecs.push_back(v);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic rst, input logic sv, input logic [7:0] sd, input logic mr);
        rst_i = rst; s_valid_i = sv; s_data_i = sd; m_ready_i = mr;
    endtask

    logic [7:0] exp_q[$];

    initial begin
        drive(1'b1, 1'b0, 8'h00, 1'b0);

        // rst sv  sd     mr    mv sr fill af cd md
        add(1, 0, 8'h00, 0,   0, 0, 0, 0, 0, 8'h00);
        add(1, 0, 8'h00, 0,   0, 0, 0, 0, 0, 8'h00);
        add(0, 0, 8'h00, 0,   0, 1, 0, 0, 0, 8'h00);
        add(0, 0, 8'h00, 0,   0, 1, 0, 0, 0, 8'h00);
        // fill with consumer stalled
        add(0, 1, 8'h11, 0,   1, 1, 1, 0, 1, 8'h11);
        add(0, 1, 8'h22, 0,   1, 1, 2, 0, 1, 8'h11);
        add(0, 1, 8'h33, 0,   1, 1, 3, 1, 1, 8'h11);
        add(0, 1, 8'h44, 0,   1, 0, 4, 1, 1, 8'h11);
        add(0, 0, 8'h00, 0,   1, 0, 4, 1, 1, 8'h11);
        // drain from full
        add(0, 0, 8'h00, 1,   1, 1, 3, 1, 1, 8'h22);
        add(0, 0, 8'h00, 1,   1, 1, 2, 0, 1, 8'h33);
        add(0, 0, 8'h00, 1,   1, 1, 1, 0, 1, 8'h44);
        add(0, 0, 8'h00, 1,   0, 1, 0, 0, 0, 8'h00);
        // refill, then push and pop together while full
        add(0, 1, 8'h61, 0,   1, 1, 1, 0, 1, 8'h61);
        add(0, 1, 8'h62, 0,   1, 1, 2, 0, 1, 8'h61);
        add(0, 1, 8'h63, 0,   1, 1, 3, 1, 1, 8'h61);
        add(0, 1, 8'h64, 0,   1, 0, 4, 1, 1, 8'h61);
        add(0, 1, 8'h55, 1,   1, 1, 3, 1, 1, 8'h62);
        add(0, 1, 8'h55, 0,   1, 0, 4, 1, 1, 8'h62);
        add(0, 0, 8'h00, 1,   1, 1, 3, 1, 1, 8'h63);
        add(0, 0, 8'h00, 1,   1, 1, 2, 0, 1, 8'h64);
        add(0, 0, 8'h00, 1,   1, 1, 1, 0, 1, 8'h55);
        add(0, 0, 8'h00, 1,   0, 1, 0, 0, 0, 8'h00);

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].rst, vecs[i].sv, vecs[i].sd, vecs[i].mr);
            step();
            chk($sformatf("row%0d m_valid", i), 32'(m_valid_o), 32'(vecs[i].mv));
            chk($sformatf("row%0d s_ready", i), 32'(s_ready_o), 32'(vecs[i].sr));
            chk($sformatf("row%0d fill", i),    32'(fill_o),    32'(vecs[i].fill));
            chk($sformatf("row%0d afull", i),   32'(afull_o),   32'(vecs[i].af));
            if (vecs[i].cd) begin
                chk($sformatf("row%0d m_data", i), 32'(m_data_o), 32'(vecs[i].md));
            end
        end

        // Sustained push+pop at fill 2; pointers wrap twice.
        drive(1'b0, 1'b1, 8'hB0, 1'b0); step();
        drive(1'b0, 1'b1, 8'hB1, 1'b0); step();
        chk("pp prefill", 32'(fill_o), 32'd2);
        exp_q = '{8'hB0, 8'hB1, 8'h00, 8'h01, 8'h02, 8'h03,
                  8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h09};
        for (int i = 0; i < 10; i++) begin
            chk($sformatf("pp%0d m_data", i), 32'(m_data_o), 32'(exp_q[i]));
            chk($sformatf("pp%0d m_valid", i), 32'(m_valid_o), 32'd1);
            drive(1'b0, 1'b1, 8'(i), 1'b1);
            step();
            chk($sformatf("pp%0d fill", i), 32'(fill_o), 32'd2);
            chk($sformatf("pp%0d s_ready", i), 32'(s_ready_o), 32'd1);
        end
        for (int i = 10; i < 12; i++) begin
            chk($sformatf("pp tail%0d m_data", i), 32'(m_data_o), 32'(exp_q[i]));
            drive(1'b0, 1'b0, 8'h00, 1'b1);
            step();
        end
        chk("pp empty m_valid", 32'(m_valid_o), 32'd0);
        chk("pp empty fill", 32'(fill_o), 32'd0);

        // Reset with fill 3; a handshake during reset is ignored.
        drive(1'b0, 1'b1, 8'hC1, 1'b0); step();
        drive(1'b0, 1'b1, 8'hC2, 1'b0); step();
        drive(1'b0, 1'b1, 8'hC3, 1'b0); step();
        chk("mid fill3", 32'(fill_o), 32'd3);
        drive(1'b1, 1'b1, 8'hEE, 1'b1); step();
        chk("mid rst fill", 32'(fill_o), 32'd0);
        chk("mid rst m_valid", 32'(m_valid_o), 32'd0);
        chk("mid rst s_ready", 32'(s_ready_o), 32'd0);
        chk("mid rst afull", 32'(afull_o), 32'd0);
        drive(1'b0, 1'b0, 8'h00, 1'b0); step();
        chk("post rst s_ready", 32'(s_ready_o), 32'd1);
        chk("post rst m_valid", 32'(m_valid_o), 32'd0);
        drive(1'b0, 1'b1, 8'hA5, 1'b0); step();
        chk("post rst push m_valid", 32'(m_valid_o), 32'd1);
        chk("post rst push m_data", 32'(m_data_o), 32'hA5);
        chk("post rst push fill", 32'(fill_o), 32'd1);
        drive(1'b0, 1'b0, 8'h00, 1'b1); step();
        chk("post rst pop m_valid", 32'(m_valid_o), 32'd0);
        chk("post rst pop fill", 32'(fill_o), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/sync_fifo.md
# sync_fifo

Parametrised synchronous FIFO with valid/ready handshake on both sides: the multi-entry generalisation of the single-stage buffer. It sits between a producer and a consumer in the same clock domain to absorb bursts and decouple back-pressure. All outputs are registered, with no combinational path from `m_ready_i` to `s_ready_o`. Fill level and almost-full status are exported for flow control upstream.

## Interface
- `G_DATA_SIZE`, 8: payload width in bits.
- `G_ADDR_SIZE`, 2: log2 of depth; depth D = 2**G_ADDR_SIZE, with G_ADDR_SIZE >= 1.
- `G_AFULL`, 3: almost-full threshold, 1..D.

- `clk_i`  in  1  clock; one clock, all logic on the rising edge.
- `rst_i`  in  1  reset; synchronous, active-high.
- `s_valid_i`  in  1  producer data valid.
- `s_ready_o`  out  1  FIFO can accept data.
- `s_data_i`  in  G_DATA_SIZE  producer payload.
- `m_valid_o`  out  1  FIFO holds data.
- `m_ready_i`  in  1  consumer accepts.
- `m_data_o`  out  G_DATA_SIZE  oldest stored word.
- `fill_o`  out  G_ADDR_SIZE+1  number of stored words, 0..D.
- `afull_o`  out  1  high when fill_o >= G_AFULL.

## Operation
- Storage: D-entry array, write pointer `wr`, read pointer `rd`, and count `cnt`. Pointers and count are G_ADDR_SIZE+1 bits wide; the array is indexed with the low G_ADDR_SIZE bits. Pointers wrap modulo 2**(G_ADDR_SIZE+1).
- Push: occurs when `s_valid_i && s_ready_o`. Writes `s_data_i` at `wr` and increments `wr`.
- Pop: occurs when `m_valid_o && m_ready_i`. Increments `rd`.
- Count update on each edge:
  - push only: `cnt+1`
  - pop only: `cnt-1`
  - both or neither: `cnt` unchanged.
- Registered flags, computed from the next count value:
  - `s_ready_o <= (cnt_next < D)`
  - `m_valid_o <= (cnt_next != 0)`
  - `fill_o <= cnt_next`
  - `afull_o <= (cnt_next >= G_AFULL)`
- `m_data_o` is the array entry at `rd`. It is a registered read, updated on each edge with the entry at the next `rd`. When pushing into an empty FIFO, the pushed word itself is forwarded into the output register.
- Full: `s_ready_o` is low, so no push occurs even if a pop happens in the same cycle. Space freed by a pop is visible the following cycle.
- Empty: `m_valid_o` is low, and `m_data_o` is don't-care.
- Handshake guarantee: while `m_valid_o && !m_ready_i`, both `m_valid_o` and `m_data_o` hold stable on the next cycle.
- Data order is strictly FIFO. No word is lost or duplicated.
- Producer obligation: while `s_valid_i && !s_ready_o`, hold `s_valid_i` and `s_data_i` stable.

## Timing
- Reset: every edge with `rst_i=1` sets:
  - `wr`, `rd`, `cnt` to 0
  - `m_valid_o=0`, `s_ready_o=0`, `fill_o=0`, `afull_o=0`.
- The first edge after `rst_i` deasserts sets `s_ready_o=1`. Handshakes presented in the same cycle as `rst_i=1` are ignored.
- Reset mid-operation: all stored words are discarded. `m_valid_o` is 0 in the cycle after the reset edge.
- Latency: a word pushed at edge N gives `m_valid_o=1` with that word on `m_data_o` after edge N. Minimum latency is 1 cycle, with no combinational bypass.
- Throughput: one push and one pop per cycle, sustained, for any fill level 1..D-1.
- Wrap-around: pointers wrap without a bubble. Full and empty are decided by `cnt`, not by pointer compare.
- `fill_o` and `afull_o` are updated on the same edge as the push/pop that changes them.

## Test plan
D=4, G_AFULL=3, G_DATA_SIZE=8 for all scenarios.

- Reset then idle: all outputs are 0 during reset. `s_ready_o=1` from the first cycle after reset; `m_valid_o` stays 0.
- Fill with `m_ready_i=0`: push 0x11, 0x22, 0x33, 0x44 on consecutive cycles.
  - `fill_o` steps 1, 2, 3, 4.
  - `afull_o` goes high once `fill_o` reaches 3.
  - `s_ready_o=0` after the 4th push.
  - `m_data_o=0x11` stays stable throughout.
- Drain: from full, hold `m_ready_i=1`. Outputs are 0x11, 0x22, 0x33, 0x44 on four consecutive cycles. Then `m_valid_o=0`, `fill_o=0`, `s_ready_o=1`.
- Simultaneous push/pop at fill 2: drive `s_valid_i` and `m_ready_i` for 10 cycles with data 0x00..0x09.
  - `fill_o` stays at 2.
  - The output sequence is the two pre-stored words followed by 0x00..0x07.
  - Pointers wrap twice with no stall.
- Full plus pop: with the FIFO full, `s_valid_i=1` (0x55) and `m_ready_i=1` in the same cycle.
  - 0x55 is not accepted that cycle and `fill_o` drops to 3.
  - 0x55 is accepted the next cycle and eventually emerges in order.
- Reset mid-stream: with fill 3, assert `rst_i` for 1 cycle. Afterwards `fill_o=0` and `m_valid_o=0`. A subsequent push of 0xA5 emerges as the first output.
